// File: rtl/mem_access.sv
// mem_access: data-memory access stage between EXE/MEM and MEM/WB.
// Owns a word-organised data RAM (2^DMW words of DW bits). Executes RV32I
// loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW). Each memory operation
// is held for LAT cycles. Every other instruction passes through in one cycle.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid        upstream offers inst/addr/wdata/rd
//   in_ready        stage can accept (IDLE only)
//   inst            instruction from EXE/MEM
//   addr            effective address or pass-through ALU result
//   wdata           store data (rs2)
//   rd              destination register
//   out_valid       one-cycle pulse qualifying out/out_inst/rd_o
//   out             load data or pass-through result (0 for stores)
//   out_inst        instruction forwarded to MEM/WB
//   rd_o            destination register (0 for stores)
//   stall           high whenever the stage is busy
//   fault           sticky misalignment flag
//
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned accesses.
// When it is defined, a misaligned access sets fault, the write is suppressed,
// and a misaligned load returns 0/rd 0. When it is undefined, misaligned
// addresses are force-aligned and fault stays 0.
module mem_access #(
    parameter int DW  = 32,
    parameter int IW  = 32,
    parameter int RFW = 5,
    parameter int DMW = 6,
    parameter int LAT = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [IW-1:0]  inst,
    input  logic [DW-1:0]  addr,
    input  logic [DW-1:0]  wdata,
    input  logic [RFW-1:0] rd,
    output logic           out_valid,
    output logic [DW-1:0]  out,
    output logic [IW-1:0]  out_inst,
    output logic [RFW-1:0] rd_o,
    output logic           stall,
    output logic           fault
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    function automatic logic f_is_load(input logic [6:0] op, input logic [2:0] f3);
        return (op == OP_LOAD) && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
                                   f3 == 3'b100 || f3 == 3'b101);
    endfunction

    function automatic logic f_is_store(input logic [6:0] op, input logic [2:0] f3);
        return (op == OP_STORE) && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
    endfunction

    // Right-justified lane data is extended according to funct3.
    function automatic logic [DW-1:0] f_extend(input logic [2:0] f3, input logic [DW-1:0] s);
        case (f3)
            3'b000:  return {{(DW-8){s[7]}}, s[7:0]};
            3'b001:  return {{(DW-16){s[15]}}, s[15:0]};
            3'b100:  return {{(DW-8){1'b0}}, s[7:0]};
            3'b101:  return {{(DW-16){1'b0}}, s[15:0]};
            default: return s;
        endcase
    endfunction

    state_t             r_state, w_next;
    logic [2:0]         r_cnt;
    logic [IW-1:0]      r_inst;
    logic [DMW+1:0]     r_addr;
    logic [DW-1:0]      r_wdata;
    logic [RFW-1:0]     r_rd;
    logic [DW-1:0]      r_out;
    logic [RFW-1:0]     r_rd_o;
    logic [DW-1:0]      r_ram [0:(2**DMW)-1];

    logic               w_accept;
    logic               w_in_mem;
    logic               w_commit;
    logic [2:0]         w_f3;
    logic               w_load;
    logic               w_store;
    logic               w_suppress;
    logic [1:0]         w_off;
    logic [DMW-1:0]     w_idx;
    logic [DW-1:0]      w_rshift;
    logic [DW-1:0]      w_ldata;
    logic [DW-1:0]      w_wshift;
    logic [3:0]         w_be;

    assign w_in_mem = f_is_load(inst[6:0], inst[14:12]) | f_is_store(inst[6:0], inst[14:12]);
    assign w_f3     = r_inst[14:12];
    assign w_load   = f_is_load(r_inst[6:0], w_f3);
    assign w_store  = f_is_store(r_inst[6:0], w_f3);
    assign w_commit = (r_state == S_ACCESS) && (r_cnt == 3'd0);
    assign w_idx    = r_addr[DMW+1:2];

    // Lane offset is force-aligned to the access size; the trap build
    // suppresses misaligned accesses separately, so this is safe in both.
    always_comb begin
        w_off = 2'b00;
        w_be  = 4'b1111;
        case (w_f3[1:0])
            2'b00: begin
                w_off = r_addr[1:0];
                w_be  = 4'b0001 << r_addr[1:0];
            end
            2'b01: begin
                w_off = {r_addr[1], 1'b0};
                w_be  = 4'b0011 << {r_addr[1], 1'b0};
            end
            default: begin
                w_off = 2'b00;
                w_be  = 4'b1111;
            end
        endcase
    end

    assign w_rshift = r_ram[w_idx] >> {w_off, 3'b000};
    assign w_ldata  = f_extend(w_f3, w_rshift);
    assign w_wshift = r_wdata << {w_off, 3'b000};

`ifdef MEM_MISALIGN_TRAP_EN
    logic w_misalign;
    logic r_fault;
    assign w_misalign = (w_f3[1:0] == 2'b01 && r_addr[0]) ||
                        (w_f3[1:0] == 2'b10 && r_addr[1:0] != 2'b00);
    assign w_suppress = w_misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_fault <= 1'b0;
        else if (w_commit && w_misalign)
            r_fault <= 1'b1;
    end
    assign fault = r_fault;
`else
    assign w_suppress = 1'b0;
    assign fault      = 1'b0;
`endif

    // FSM state and latency counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_next;
            if (w_accept && w_in_mem)
                r_cnt <= 3'(LAT - 1);
            else if (r_state == S_ACCESS && r_cnt != 3'd0)
                r_cnt <= r_cnt - 3'd1;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        in_ready  = 1'b0;
        stall     = 1'b1;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                stall    = 1'b0;
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = w_in_mem ? S_ACCESS : S_DONE;
                end
            end
            S_ACCESS: begin
                if (r_cnt == 3'd0)
                    w_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand latch: held for the whole operation, no reset needed
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr  <= addr[DMW+1:0];
            r_wdata <= wdata;
            r_rd    <= rd;
        end
    end

    // Result registers driving MEM/WB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out  <= '0;
            r_rd_o <= '0;
            r_inst <= '0;
        end else if (w_accept) begin
            r_inst <= inst;
            if (!w_in_mem) begin
                r_out  <= addr;
                r_rd_o <= rd;
            end
        end else if (w_commit) begin
            if (w_load && !w_suppress) begin
                r_out  <= w_ldata;
                r_rd_o <= r_rd;
            end else begin
                r_out  <= '0;
                r_rd_o <= '0;
            end
        end
    end

    // Data RAM: byte-lane write on the final access cycle
    always_ff @(posedge clk) begin
        if (w_commit && w_store && !w_suppress) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b])
                    r_ram[w_idx][8*b +: 8] <= w_wshift[8*b +: 8];
            end
        end
    end

    assign out      = r_out;
    assign rd_o     = r_rd_o;
    assign out_inst = r_inst;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

    localparam int LAT = 2;
    localparam logic [6:0] OPL = 7'b0000011;
    localparam logic [6:0] OPS = 7'b0100011;
    localparam logic [6:0] OPR = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] inst = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [4:0]  rd = '0;
    logic        out_valid;
    logic [31:0] out;
    logic [31:0] out_inst;
    logic [4:0]  rd_o;
    logic        stall;
    logic        fault;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] out;
        logic [4:0]  rd;
        logic [31:0] inst;
        int          due;
    } exp_t;
    exp_t sb[$];

    mem_access #(.DW(32), .IW(32), .RFW(5), .DMW(6), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .addr(addr), .wdata(wdata), .rd(rd),
        .out_valid(out_valid), .out(out), .out_inst(out_inst), .rd_o(rd_o),
        .stall(stall), .fault(fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
        return {17'd0, f3, 5'd0, op};
    endfunction

    // Scoreboard consumer: every out_valid pulse must match the oldest entry
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            tests++;
            assert (sb.size() > 0) else begin
                fails++;
                $error("FAIL unexpected_out_valid: observed out %h expected no output", out);
            end
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("out", out, e.out);
                chk("rd_o", {27'd0, rd_o}, {27'd0, e.rd});
                chk("out_inst", out_inst, e.inst);
                chk("latency", cyc, e.due);
            end
        end
    end

    // Called on a negedge with the stage idle; returns on the negedge after completion.
    task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] r, input logic [31:0] eout, input logic [4:0] erd,
                         input bit mem);
        exp_t e;
        int   n;
        bit   done;
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        inst = ins; addr = a; wdata = wd; rd = r; in_valid = 1'b1;
        e.out = eout; e.rd = erd; e.inst = ins;
        e.due = cyc + (mem ? LAT + 1 : 1);
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        inst = $urandom; addr = $urandom; wdata = $urandom; rd = 5'($urandom);
        n = 0;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (stall) n++;
            else done = 1'b1;
        end
        chk("stall_cycles", n, mem ? LAT + 1 : 1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out", out, 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_rd_o", {27'd0, rd_o}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Word store/load
        issue(mk(OPS, 3'b010), 32'h10, 32'hDEADBEEF, 5'd4, 32'h0, 5'd0, 1);
        issue(mk(OPL, 3'b010), 32'h10, 32'h0, 5'd5, 32'hDEADBEEF, 5'd5, 1);

        // Byte lane store and sign/zero extension
        issue(mk(OPS, 3'b010), 32'h20, 32'h11223344, 5'd1, 32'h0, 5'd0, 1);
        issue(mk(OPS, 3'b000), 32'h21, 32'h12345680, 5'd1, 32'h0, 5'd0, 1);
        issue(mk(OPL, 3'b000), 32'h21, 32'h0, 5'd6, 32'hFFFFFF80, 5'd6, 1);
        issue(mk(OPL, 3'b100), 32'h21, 32'h0, 5'd6, 32'h00000080, 5'd6, 1);
        issue(mk(OPL, 3'b010), 32'h20, 32'h0, 5'd8, 32'h11228044, 5'd8, 1);

        // Halfword store and loads
        issue(mk(OPS, 3'b001), 32'h22, 32'hCAFEBEEF, 5'd1, 32'h0, 5'd0, 1);
        issue(mk(OPL, 3'b001), 32'h22, 32'h0, 5'd10, 32'hFFFFBEEF, 5'd10, 1);
        issue(mk(OPL, 3'b101), 32'h22, 32'h0, 5'd11, 32'h0000BEEF, 5'd11, 1);
        issue(mk(OPL, 3'b001), 32'h20, 32'h0, 5'd12, 32'hFFFF8044, 5'd12, 1);
        issue(mk(OPL, 3'b000), 32'h23, 32'h0, 5'd13, 32'hFFFFFFBE, 5'd13, 1);

        // Pass-through, back to back, and LOAD with an illegal funct3
        issue(mk(OPR, 3'b000), 32'h1234, 32'h0, 5'd7, 32'h1234, 5'd7, 0);
        issue(mk(OPR, 3'b111), 32'hCAFE0001, 32'h0, 5'd9, 32'hCAFE0001, 5'd9, 0);
        issue(mk(OPL, 3'b011), 32'h40, 32'h0, 5'd3, 32'h40, 5'd3, 0);

        // Address wrap modulo 2^(DMW+2) bytes
        issue(mk(OPS, 3'b010), 32'h100, 32'h5A5AA5A5, 5'd2, 32'h0, 5'd0, 1);
        issue(mk(OPL, 3'b010), 32'h000, 32'h0, 5'd14, 32'h5A5AA5A5, 5'd14, 1);

        // Reset during ACCESS aborts a pending store
        issue(mk(OPS, 3'b010), 32'h8, 32'h12345678, 5'd2, 32'h0, 5'd0, 1);
        inst = mk(OPS, 3'b010); addr = 32'h8; wdata = 32'hAAAA5555; rd = 5'd2; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("abort_stall_before", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_out", out, 32'd0);
        chk("abort_rd_o", {27'd0, rd_o}, 32'd0);
        chk("abort_out_inst", out_inst, 32'd0);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_stall", {31'd0, stall}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(mk(OPL, 3'b010), 32'h8, 32'h0, 5'd15, 32'h12345678, 5'd15, 1);

        // Misaligned halfword load
        issue(mk(OPS, 3'b010), 32'h0, 32'h87654321, 5'd2, 32'h0, 5'd0, 1);
`ifdef MEM_MISALIGN_TRAP_EN
        issue(mk(OPL, 3'b001), 32'h3, 32'h0, 5'd16, 32'h0, 5'd0, 1);
        chk("fault_set", {31'd0, fault}, 32'd1);
        issue(mk(OPR, 3'b000), 32'h55, 32'h0, 5'd1, 32'h55, 5'd1, 0);
        chk("fault_sticky", {31'd0, fault}, 32'd1);
`else
        issue(mk(OPL, 3'b001), 32'h3, 32'h0, 5'd16, 32'hFFFF8765, 5'd16, 1);
        chk("fault_clear", {31'd0, fault}, 32'd0);
        issue(mk(OPL, 3'b101), 32'h1, 32'h0, 5'd17, 32'h00004321, 5'd17, 1);
        chk("fault_still_clear", {31'd0, fault}, 32'd0);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Data-memory access stage of the five-stage core, between the EXE/MEM and MEM/WB pipeline buffers. The stage owns a word-organised synchronous data RAM and executes RV32I-encoded loads and stores with byte, half and word sizes and sign or zero extension. It holds each memory operation for a fixed multi-cycle latency and raises a stall while busy. Non-memory instructions pass through with one cycle of latency.

## Interface
- DW, 32, data width; fixed at 32 for the byte-lane logic
- IW, 32, instruction width
- RFW, 5, register-address width
- DMW, 6, data RAM word-address width, giving 2^DMW words
- LAT, 2, RAM access cycles; legal range 1..7

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream has an instruction in inst/addr/wdata/rd
- in_ready  out  1  stage can accept; high only in IDLE
- inst  in  IW  instruction from EXE/MEM
- addr  in  DW  ALU result: effective address, or the pass-through result
- wdata  in  DW  store data (rs2 value)
- rd  in  RFW  destination register
- out_valid  out  1  single-cycle pulse; out/out_inst/rd_o are valid
- out  out  DW  load data or pass-through result
- out_inst  out  IW  instruction forwarded to MEM/WB
- rd_o  out  RFW  destination register; forced to 0 for stores
- stall  out  1  high while state is not IDLE; freezes upstream stages
- fault  out  1  sticky misalignment flag; always 0 unless MEM_MISALIGN_TRAP_EN is defined

## Operation
- Decode: opcode inst[6:0]; LOAD = 7'b0000011, STORE = 7'b0100011; funct3 inst[14:12].
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other funct3 on LOAD or STORE is treated as pass-through.
- Addressing: word index is addr[DMW+1:2]. Higher address bits are ignored, so addresses wrap modulo 2^(DMW+2) bytes. addr[1:0] selects the byte lane.
- Stores: SB writes lane addr[1:0]. SH writes lanes {addr[1],0} and {addr[1],1}. SW writes all four lanes. Unselected lanes are unchanged.
- Loads: the selected lane(s) are right-justified. Sign extension applies for LB/LH; zero extension for LBU/LHU.
- Misalignment: LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] != 0.
- FSM states:
  - IDLE: in_ready = 1. On in_valid:
    - memory op → ACCESS with cnt = LAT-1.
    - other op → DONE.
  - ACCESS: cnt decrements each cycle. When cnt = 0:
    - a store commits its write to RAM.
    - a load captures its read data.
    - state → DONE.
  - DONE: out_valid = 1 for exactly this cycle, then → IDLE.
- Inputs are latched on accept; upstream changes while busy are ignored.
- Pass-through: out = addr, rd_o = rd.
- Store: out = 0, rd_o = 0, so the store never causes a register-file write.
- RAM contents are not reset and are undefined until written.

## Timing
- Accept edge: in_valid & in_ready.
- out_valid latency from the accept edge:
  - memory op: LAT+1 cycles.
  - non-memory op: 1 cycle.
- in_ready is low from the cycle after accept through the DONE cycle. The next accept is possible on the cycle after DONE.
- Back-to-back pass-through ops give a throughput of one instruction every 2 cycles.
- A store's RAM write is visible to a load accepted after that store's DONE cycle.
- Reset values: state IDLE; in_ready 1; stall 0; out_valid 0; out 0; out_inst 0; rd_o 0; fault 0.
- Reset mid-ACCESS aborts the operation. A pending store does not write, and out_valid is not produced.
- There is no output backpressure: MEM/WB captures on every out_valid.

## Configuration
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined: a misaligned access sets fault (sticky until rst). A misaligned store performs no write. A misaligned load returns out = 0 with rd_o = 0. Latency is unchanged.
- Undefined: fault is tied 0. Misaligned addresses are force-aligned: addr[0] is cleared for halfword ops, and addr[1:0] is cleared for word ops. The access then proceeds normally.

## Test plan
- SW 0xDEADBEEF to addr 0x10, then LW addr 0x10 → out 0xDEADBEEF. out_valid arrives exactly LAT+1 cycles after each accept; stall is high for LAT+1 cycles.
- SB 0x80 to 0x21, then:
  - LB 0x21 → 0xFFFFFF80.
  - LBU 0x21 → 0x00000080.
  - LW 0x20 → other lanes unchanged from a prior SW 0x11223344, giving 0x11228044.
- Pass-through op with addr = 0x1234 and rd = 7 → out 0x1234, rd_o 7, out_valid one cycle after accept. A store yields rd_o = 0.
- Wrap-around: with DMW = 6, SW to 0x100 then LW 0x000 → same data.
- Assert rst during the ACCESS phase of SW 0xAAAA5555 to 0x8. All outputs must read 0 immediately. A subsequent LW 0x8 returns the previously stored value.
- LH at 0x3:
  - with MEM_MISALIGN_TRAP_EN: fault = 1 and stays 1; out = 0; rd_o = 0.
  - without: reads the halfword at 0x2, and fault = 0.
